// File: rtl/prio_encoder_4to2_if.sv
// Handshake/request bundle for the round-robin 4-to-2 encoder.
// The encoder uses the slave modport; the request/consumer side uses master.
interface prio_encoder_4to2_if;
  logic [3:0] req_i;
  logic       en_i;
  logic       ready_i;
  logic [1:0] data_o;
  logic       valid_o;
  logic [3:0] pend_o;
  logic       overflow_o;

  modport master (
    output req_i,
    output en_i,
    output ready_i,
    input  data_o,
    input  valid_o,
    input  pend_o,
    input  overflow_o
  );

  modport slave (
    input  req_i,
    input  en_i,
    input  ready_i,
    output data_o,
    output valid_o,
    output pend_o,
    output overflow_o
  );
endinterface

// File: rtl/prio_encoder_4to2.sv
// Registered round-robin 4-to-2 encoder: latches request pulses into a pending
// register and issues one pending index at a time over a valid/ready handshake.
module prio_encoder_4to2 (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  prio_encoder_4to2_if.slave   bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t     state_r;
  logic [1:0] data_r;
  logic       valid_r;
  logic [3:0] pend_r;
  logic       overflow_r;
  logic [1:0] ptr_r;

  logic       accept_s;
  logic [3:0] clr_s;
  logic [3:0] pend_nxt_s;
  logic [3:0] lost_s;
  logic [2:0] pick_s;

  // Returns {found, index} of the first set pending bit starting at ptr.
  function automatic logic [2:0] rr_pick(input logic [3:0] pend, input logic [1:0] ptr);
    logic       found;
    logic [1:0] idx;
    logic [1:0] pick;
    found = 1'b0;
    pick  = 2'b00;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && pend[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return {found, pick};
  endfunction

  // Acceptance clear mask, next pending value and lost-request detection.
  always_comb begin
    clr_s    = 4'b0000;
    accept_s = valid_r & bus.ready_i;
    if (accept_s) begin
      clr_s[data_r] = 1'b1;
    end else begin
      clr_s = 4'b0000;
    end
    pend_nxt_s = bus.req_i | (pend_r & ~clr_s);
    lost_s     = bus.req_i & pend_r & ~clr_s;
    pick_s     = rr_pick(pend_r, ptr_r);
  end

  // Pending capture, sticky overflow and the IDLE/VALID grant machine.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r    <= IDLE;
      data_r     <= 2'b00;
      valid_r    <= 1'b0;
      pend_r     <= 4'b0000;
      overflow_r <= 1'b0;
      ptr_r      <= 2'b00;
    end else begin
      pend_r <= pend_nxt_s;
      if (|lost_s) begin
        overflow_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          // Selection looks only at the registered pending bits.
          if (bus.en_i && pick_s[2]) begin
            data_r  <= pick_s[1:0];
            valid_r <= 1'b1;
            state_r <= VALID;
          end else begin
            state_r <= IDLE;
          end
        end
        VALID: begin
          if (accept_s) begin
            ptr_r   <= data_r + 2'd1;
            valid_r <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= VALID;
          end
        end
        default: begin
          valid_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_o     = data_r;
  assign bus.valid_o    = valid_r;
  assign bus.pend_o     = pend_r;
  assign bus.overflow_o = overflow_r;

endmodule

// File: tb/tb_prio_encoder_4to2.sv
// Self-checking bench for prio_encoder_4to2: directed table, corner sequences
// and randomized traffic compared against a cycle-level behavioural model.
module tb_prio_encoder_4to2;

  logic clk;
  logic rst_n;

  prio_encoder_4to2_if bus ();

  prio_encoder_4to2 dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Behavioural model state
  int m_pend[4];
  int m_ptr;
  int m_valid;
  int m_data;
  int m_ovf;

  typedef struct {
    logic [3:0] req;
    logic       en;
    logic       rdy;
    logic       v;
    logic [1:0] d;
    logic [3:0] p;
    logic       o;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_pend();
    int v;
    v = 0;
    for (int k = 0; k < 4; k++) v += m_pend[k] << k;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_pend[k] = 0;
    m_ptr = 0; m_valid = 0; m_data = 0; m_ovf = 0;
  endtask

  // One rising edge of the model using the inputs present before the edge.
  task automatic model_edge(input logic [3:0] r, input logic e, input logic rd);
    int np[4];
    int acc;
    int found;
    acc = (m_valid == 1 && rd == 1'b1) ? 1 : 0;
    for (int k = 0; k < 4; k++) begin
      int cleared;
      cleared = (acc == 1 && m_data == k) ? 1 : 0;
      np[k] = (r[k] == 1'b1 || (m_pend[k] == 1 && cleared == 0)) ? 1 : 0;
      if (r[k] == 1'b1 && m_pend[k] == 1 && cleared == 0) m_ovf = 1;
    end
    if (m_valid == 1) begin
      if (acc == 1) begin
        m_ptr = (m_data + 1) % 4;
        m_valid = 0;
      end
    end else if (e == 1'b1 && model_pend() != 0) begin
      found = 0;
      for (int i = 0; i < 4; i++) begin
        if (found == 0 && m_pend[(m_ptr + i) % 4] == 1) begin
          found = 1;
          m_data = (m_ptr + i) % 4;
        end
      end
      m_valid = 1;
    end
    for (int k = 0; k < 4; k++) m_pend[k] = np[k];
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".valid"}, int'(bus.valid_o), m_valid);
    check({tag, ".pend"}, int'(bus.pend_o), model_pend());
    check({tag, ".ovf"}, int'(bus.overflow_o), m_ovf);
    if (m_valid == 1) check({tag, ".data"}, int'(bus.data_o), m_data);
  endtask

  // Drive inputs, take one edge, advance the model and compare 1 ns later.
  task automatic step(input logic [3:0] r, input logic e, input logic rd, input string tag);
    bus.req_i = r; bus.en_i = e; bus.ready_i = rd;
    @(posedge clk);
    model_edge(r, e, rd);
    #1;
    compare_model(tag);
  endtask

  task automatic do_reset();
    bus.req_i = 4'b0000; bus.en_i = 1'b0; bus.ready_i = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compare_model("reset");
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b1;
    bus.req_i = 4'b0000; bus.en_i = 1'b0; bus.ready_i = 1'b0;

    //             req      en    rdy   v     d      p        o
    tbl[0]  = '{4'b1111, 1'b1, 1'b1, 1'b0, 2'd0, 4'b1111, 1'b0};
    tbl[1]  = '{4'b0000, 1'b1, 1'b1, 1'b1, 2'd0, 4'b1111, 1'b0};
    tbl[2]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 4'b1110, 1'b0};
    tbl[3]  = '{4'b0000, 1'b1, 1'b1, 1'b1, 2'd1, 4'b1110, 1'b0};
    tbl[4]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd1, 4'b1100, 1'b0};
    tbl[5]  = '{4'b0000, 1'b1, 1'b1, 1'b1, 2'd2, 4'b1100, 1'b0};
    tbl[6]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd2, 4'b1000, 1'b0};
    tbl[7]  = '{4'b0000, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0};
    tbl[8]  = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0};
    tbl[9]  = '{4'b1001, 1'b1, 1'b1, 1'b0, 2'd3, 4'b1001, 1'b0};
    tbl[10] = '{4'b0000, 1'b1, 1'b1, 1'b1, 2'd0, 4'b1001, 1'b0};
    tbl[11] = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b0};
    tbl[12] = '{4'b0000, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0};
    tbl[13] = '{4'b0000, 1'b1, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0};

    // Table: round-robin 0,1,2,3 then 1001 -> 0,3
    do_reset();
    check("reset.data", int'(bus.data_o), 0);
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].req, tbl[i].en, tbl[i].rdy, "tbl");
      check($sformatf("tbl%0d.valid", i), int'(bus.valid_o), int'(tbl[i].v));
      check($sformatf("tbl%0d.data", i), int'(bus.data_o), int'(tbl[i].d));
      check($sformatf("tbl%0d.pend", i), int'(bus.pend_o), int'(tbl[i].p));
      check($sformatf("tbl%0d.ovf", i), int'(bus.overflow_o), int'(tbl[i].o));
    end

    // Single request 0100: grant 2, accept, then ptr=3 so next 1111 grants 3 first
    do_reset();
    step(4'b0100, 1'b1, 1'b1, "single");
    check("single.v_after1", int'(bus.valid_o), 0);
    step(4'b0000, 1'b1, 1'b1, "single");
    check("single.valid", int'(bus.valid_o), 1);
    check("single.data", int'(bus.data_o), 2);
    step(4'b0000, 1'b1, 1'b1, "single");
    check("single.pend", int'(bus.pend_o), 0);
    check("single.v_acc", int'(bus.valid_o), 0);
    step(4'b1111, 1'b1, 1'b1, "single");
    step(4'b0000, 1'b1, 1'b1, "single");
    check("single.ptr3", int'(bus.data_o), 3);

    // Backpressure on index 1 and sticky overflow
    do_reset();
    step(4'b0010, 1'b1, 1'b0, "bp");
    step(4'b0000, 1'b1, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      step((i == 2) ? 4'b0010 : 4'b0000, 1'b0, 1'b0, "bp");
      check("bp.hold_valid", int'(bus.valid_o), 1);
      check("bp.hold_data", int'(bus.data_o), 1);
    end
    check("bp.ovf", int'(bus.overflow_o), 1);
    step(4'b0000, 1'b1, 1'b1, "bp");
    check("bp.pend1", int'(bus.pend_o[1]), 0);
    check("bp.ovf_sticky", int'(bus.overflow_o), 1);

    // Simultaneous clear and re-request on index 2
    do_reset();
    step(4'b0100, 1'b1, 1'b0, "sim");
    step(4'b0001, 1'b1, 1'b0, "sim");
    check("sim.grant2", int'(bus.data_o), 2);
    step(4'b0100, 1'b1, 1'b1, "sim");
    check("sim.pend", int'(bus.pend_o), 5);
    check("sim.ovf", int'(bus.overflow_o), 0);
    step(4'b0000, 1'b1, 1'b1, "sim");
    check("sim.next0", int'(bus.data_o), 0);
    step(4'b0000, 1'b1, 1'b1, "sim");
    step(4'b0000, 1'b1, 1'b1, "sim");
    check("sim.next2", int'(bus.data_o), 2);

    // Enable gating
    do_reset();
    step(4'b1000, 1'b0, 1'b1, "en");
    for (int i = 0; i < 4; i++) begin
      step(4'b0000, 1'b0, 1'b1, "en");
      check("en.idle", int'(bus.valid_o), 0);
    end
    step(4'b0000, 1'b1, 1'b0, "en");
    check("en.valid", int'(bus.valid_o), 1);
    check("en.data", int'(bus.data_o), 3);
    step(4'b0000, 1'b0, 1'b0, "en");
    step(4'b0000, 1'b0, 1'b0, "en");
    check("en.kept", int'(bus.valid_o), 1);
    step(4'b0000, 1'b0, 1'b1, "en");
    check("en.acc", int'(bus.valid_o), 0);

    // Asynchronous reset mid-VALID with data=2
    do_reset();
    step(4'b0100, 1'b1, 1'b0, "arst");
    step(4'b0010, 1'b1, 1'b0, "arst");
    check("arst.pre", int'(bus.data_o), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid", int'(bus.valid_o), 0);
    check("arst.data", int'(bus.data_o), 0);
    check("arst.pend", int'(bus.pend_o), 0);
    check("arst.ovf", int'(bus.overflow_o), 0);
    model_reset();
    bus.req_i = 4'b0000; bus.en_i = 1'b1; bus.ready_i = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 1'b1, 1'b0, "arst_post");
      check("arst.post_idle", int'(bus.valid_o), 0);
    end

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      step(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
